neurram_spi_responder: RTL and testbench

NEURRAM_SPI_RESPONDER -- requirements
Module: neurram_spi_responder

---
 rtl/neurram_spi_responder_if.sv | 36 +++
 rtl/neurram_spi_responder.sv | 177 +++++++++++++++++
 tb/tb_neurram_spi_responder.sv | 356 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/neurram_spi_responder_if.sv
// Bus bundle between the host controller and the NeuRRAM SPI responder.
//   spi_clk, shift_in, shift_out : serial clock and two-lane serial data
//   load_data/load_valid/load_ready : parallel preload of the shift chain
//   cap_data/cap_valid/cap_ready    : captured frame hand-off to the host
//   frame_active, overrun, timeout_err, err_clear : status and error control
// Lane packing of load_data/cap_data: lane0 in the lower spi_length bits,
// lane1 in the upper half.
interface neurram_spi_responder_if #(
    parameter int spi_length = 256
);
    logic                    spi_clk;
    logic [1:0]              shift_in;
    logic [1:0]              shift_out;
    logic [2*spi_length-1:0] load_data;
    logic                    load_valid;
    logic                    load_ready;
    logic [2*spi_length-1:0] cap_data;
    logic                    cap_valid;
    logic                    cap_ready;
    logic                    frame_active;
    logic                    overrun;
    logic                    timeout_err;
    logic                    err_clear;

    modport master (
        output spi_clk, shift_in, load_data, load_valid, cap_ready, err_clear,
        input  shift_out, load_ready, cap_data, cap_valid, frame_active,
               overrun, timeout_err
    );

    modport slave (
        input  spi_clk, shift_in, load_data, load_valid, cap_ready, err_clear,
        output shift_out, load_ready, cap_data, cap_valid, frame_active,
               overrun, timeout_err
    );
endinterface

// File: rtl/neurram_spi_responder.sv
// Two-lane SPI-style shift-chain responder for the NeuRRAM host link.
// Each rising edge of spi_clk (synchronous to clk) shifts one bit per lane
// LSB-first into a spi_length-bit chain; after spi_length edges the chain is
// captured into cap_data. The chain persists between frames so the host reads
// back the previous frame (or a preload) while shifting in the next one.
// Ports:
//   clk  : system clock, all logic on its rising edge
//   rst  : asynchronous active-high reset
//   bus  : slave side of neurram_spi_responder_if (serial, preload, capture,
//          status and error signals)
module neurram_spi_responder #(
    parameter int spi_length     = 256,
    parameter int timeout_cycles = 1024
) (
    input logic                    clk,
    input logic                    rst,
    neurram_spi_responder_if.slave bus
);

    localparam int CNT_W = $clog2(spi_length) + 1;
    localparam int IDL_W = $clog2(timeout_cycles) + 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(spi_length);
    localparam logic [IDL_W-1:0] IDLE_MAX = IDL_W'(timeout_cycles);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHIFTING = 2'd1,
        CAPTURE  = 2'd2
    } state_t;

    state_t                  state, state_nxt;
    logic [CNT_W-1:0]        bit_cnt, bit_cnt_nxt;
    logic [IDL_W-1:0]        idle_cnt, idle_cnt_nxt;
    logic                    spi_clk_d;
    logic                    spi_edge;
    logic [spi_length-1:0]   chain0, chain1;
    logic                    do_load;
    logic                    do_capture;
    logic                    set_overrun;
    logic                    set_timeout;
    logic [2*spi_length-1:0] cap_data_q;
    logic                    cap_valid_q;
    logic                    overrun_q;
    logic                    timeout_q;

    assign spi_edge       = bus.spi_clk & ~spi_clk_d;
    // An spi_clk edge always wins over a coincident preload; the preload
    // simply stays pending until the FSM is idle with no edge.
    assign bus.load_ready = (state == IDLE) & ~spi_edge;
    assign do_load        = bus.load_valid & bus.load_ready;

    assign bus.shift_out    = {chain1[0], chain0[0]};
    assign bus.cap_data     = cap_data_q;
    assign bus.cap_valid    = cap_valid_q;
    assign bus.overrun      = overrun_q;
    assign bus.timeout_err  = timeout_q;
    assign bus.frame_active = (state == SHIFTING);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            idle_cnt <= '0;
        end else begin
            state    <= state_nxt;
            bit_cnt  <= bit_cnt_nxt;
            idle_cnt <= idle_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        bit_cnt_nxt  = bit_cnt;
        idle_cnt_nxt = '0;
        do_capture   = 1'b0;
        set_overrun  = 1'b0;
        set_timeout  = 1'b0;
        case (state)
            IDLE: begin
                bit_cnt_nxt = '0;
                if (spi_edge) begin
                    state_nxt   = SHIFTING;
                    bit_cnt_nxt = CNT_W'(1);
                end
            end
            SHIFTING: begin
                if (spi_edge) begin
                    if (bit_cnt + CNT_W'(1) == LAST_BIT) begin
                        state_nxt   = CAPTURE;
                        bit_cnt_nxt = '0;
                    end else begin
                        bit_cnt_nxt = bit_cnt + CNT_W'(1);
                    end
                end else if (idle_cnt + IDL_W'(1) == IDLE_MAX) begin
                    // Host stalled mid-frame: abandon the frame, keep the chain.
                    state_nxt   = IDLE;
                    bit_cnt_nxt = '0;
                    set_timeout = 1'b1;
                end else begin
                    idle_cnt_nxt = idle_cnt + IDL_W'(1);
                end
            end
            CAPTURE: begin
                // Capture reads the chain before any coincident shift lands.
                if (!cap_valid_q || bus.cap_ready) begin
                    do_capture = 1'b1;
                end else begin
                    set_overrun = 1'b1;
                end
                if (spi_edge) begin
                    state_nxt   = SHIFTING;
                    bit_cnt_nxt = CNT_W'(1);
                end else begin
                    state_nxt   = IDLE;
                    bit_cnt_nxt = '0;
                end
            end
            default: begin
                state_nxt   = IDLE;
                bit_cnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            spi_clk_d <= 1'b0;
        end else begin
            spi_clk_d <= bus.spi_clk;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain0 <= '0;
            chain1 <= '0;
        end else if (spi_edge) begin
            chain0 <= {bus.shift_in[0], chain0[spi_length-1:1]};
            chain1 <= {bus.shift_in[1], chain1[spi_length-1:1]};
        end else if (do_load) begin
            chain0 <= bus.load_data[spi_length-1:0];
            chain1 <= bus.load_data[2*spi_length-1:spi_length];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_data_q  <= '0;
            cap_valid_q <= 1'b0;
        end else if (do_capture) begin
            cap_data_q  <= {chain1, chain0};
            cap_valid_q <= 1'b1;
        end else if (cap_valid_q && bus.cap_ready) begin
            cap_valid_q <= 1'b0;
        end
    end

    // Sticky flags: a set event in the same cycle as err_clear wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            if (set_overrun) begin
                overrun_q <= 1'b1;
            end else if (bus.err_clear) begin
                overrun_q <= 1'b0;
            end
            if (set_timeout) begin
                timeout_q <= 1'b1;
            end else if (bus.err_clear) begin
                timeout_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_neurram_spi_responder.sv
// Self-checking bench for neurram_spi_responder with spi_length = 16 and
// timeout_cycles = 8. A lane-level model of the shift chain predicts the
// serial readback and every captured frame.
module tb_neurram_spi_responder;

    localparam int LEN = 16;
    localparam int TMO = 8;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    // Reference model: current contents of each lane's chain.
    logic [LEN-1:0] m0;
    logic [LEN-1:0] m1;

    neurram_spi_responder_if #(.spi_length(LEN)) bus ();

    neurram_spi_responder #(
        .spi_length    (LEN),
        .timeout_cycles(TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    // Shift bits [first..last] of d0/d1 through the DUT, checking the serial
    // readback against the model before every edge.
    task automatic run_edges(input int first, input int last,
                             input logic [LEN-1:0] d0, input logic [LEN-1:0] d1,
                             input string tag);
        for (int i = first; i <= last; i++) begin
            @(negedge clk);
            checks++;
            if (bus.shift_out !== {m1[0], m0[0]}) begin
                failures++;
                $display("FAIL %s_shift_out bit=%0d got=%b exp=%b", tag, i,
                         bus.shift_out, {m1[0], m0[0]});
            end
            bus.shift_in = {d1[i], d0[i]};
            bus.spi_clk  = 1'b1;
            m0 = {d0[i], m0[LEN-1:1]};
            m1 = {d1[i], m1[LEN-1:1]};
            @(negedge clk);
            bus.spi_clk = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst            = 1'b1;
        bus.spi_clk    = 1'b0;
        bus.shift_in   = 2'b00;
        bus.load_data  = '0;
        bus.load_valid = 1'b0;
        bus.cap_ready  = 1'b1;
        bus.err_clear  = 1'b0;
        m0 = '0;
        m1 = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.shift_out, bus.cap_valid, bus.overrun, bus.timeout_err,
             bus.frame_active, bus.load_ready} !== 7'b00_0000_1) begin
            failures++;
            $display("FAIL reset_status got=%b exp=%b",
                     {bus.shift_out, bus.cap_valid, bus.overrun, bus.timeout_err,
                      bus.frame_active, bus.load_ready}, 7'b00_0000_1);
        end
        checks++;
        if (bus.cap_data !== 32'h0) begin
            failures++;
            $display("FAIL reset_cap_data got=%h exp=%h", bus.cap_data, 32'h0);
        end
    endtask

    task automatic test_basic();
        logic [LEN-1:0] d0;
        logic [LEN-1:0] d1;
        d0 = 16'hA5C3;
        d1 = 16'h0FF0;
        bus.cap_ready = 1'b1;
        run_edges(0, 0, d0, d1, "basic");
        checks++;
        if (bus.frame_active !== 1'b1) begin
            failures++;
            $display("FAIL basic_frame_active got=%b exp=1", bus.frame_active);
        end
        run_edges(1, LEN-1, d0, d1, "basic");
        @(negedge clk);
        checks++;
        if (bus.cap_valid !== 1'b1 || bus.cap_data !== 32'h0FF0_A5C3) begin
            failures++;
            $display("FAIL basic_capture got=%b/%h exp=1/%h", bus.cap_valid,
                     bus.cap_data, 32'h0FF0_A5C3);
        end
        @(negedge clk);
        checks++;
        if (bus.cap_valid !== 1'b0) begin
            failures++;
            $display("FAIL basic_cap_valid_pulse got=%b exp=0", bus.cap_valid);
        end
    endtask

    task automatic test_preload();
        @(negedge clk);
        bus.load_data  = 32'h1234_BEEF;
        bus.load_valid = 1'b1;
        #1;
        checks++;
        if (bus.load_ready !== 1'b1) begin
            failures++;
            $display("FAIL preload_ready got=%b exp=1", bus.load_ready);
        end
        @(negedge clk);
        bus.load_valid = 1'b0;
        m0 = 16'hBEEF;
        m1 = 16'h1234;
        run_edges(0, LEN-1, 16'h0, 16'h0, "preload");
        @(negedge clk);
        checks++;
        if (bus.cap_valid !== 1'b1 || bus.cap_data !== 32'h0) begin
            failures++;
            $display("FAIL preload_capture got=%b/%h exp=1/%h", bus.cap_valid,
                     bus.cap_data, 32'h0);
        end
    endtask

    task automatic test_random_frames();
        logic [LEN-1:0] d0;
        logic [LEN-1:0] d1;
        bus.cap_ready = 1'b1;
        for (int f = 0; f < 4; f++) begin
            d0 = LEN'($urandom);
            d1 = LEN'($urandom);
            run_edges(0, LEN-1, d0, d1, "random");
            @(negedge clk);
            checks++;
            if (bus.cap_valid !== 1'b1 || bus.cap_data !== {d1, d0}) begin
                failures++;
                $display("FAIL random_capture frame=%0d got=%b/%h exp=1/%h", f,
                         bus.cap_valid, bus.cap_data, {d1, d0});
            end
        end
    endtask

    task automatic test_overrun();
        logic [LEN-1:0] a0, a1, b0, b1;
        a0 = LEN'($urandom);
        a1 = LEN'($urandom);
        b0 = LEN'($urandom);
        b1 = LEN'($urandom);
        @(negedge clk);
        bus.cap_ready = 1'b0;
        run_edges(0, LEN-1, a0, a1, "overrun1");
        @(negedge clk);
        checks++;
        if (bus.cap_valid !== 1'b1 || bus.cap_data !== {a1, a0} || bus.overrun !== 1'b0) begin
            failures++;
            $display("FAIL overrun_frame1 got=%b/%h/%b exp=1/%h/0", bus.cap_valid,
                     bus.cap_data, bus.overrun, {a1, a0});
        end
        run_edges(0, LEN-1, b0, b1, "overrun2");
        @(negedge clk);
        checks++;
        if (bus.overrun !== 1'b1 || bus.cap_data !== {a1, a0} || bus.cap_valid !== 1'b1) begin
            failures++;
            $display("FAIL overrun_frame2 got=%b/%h/%b exp=1/%h/1", bus.overrun,
                     bus.cap_data, bus.cap_valid, {a1, a0});
        end
        bus.err_clear = 1'b1;
        @(negedge clk);
        bus.err_clear = 1'b0;
        checks++;
        if (bus.overrun !== 1'b0) begin
            failures++;
            $display("FAIL overrun_clear got=%b exp=0", bus.overrun);
        end
        bus.cap_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.cap_valid !== 1'b0) begin
            failures++;
            $display("FAIL overrun_drain got=%b exp=0", bus.cap_valid);
        end
    endtask

    task automatic test_timeout();
        logic [LEN-1:0] d0, d1;
        d0 = LEN'($urandom);
        d1 = LEN'($urandom);
        run_edges(0, 4, d0, d1, "timeout_part");
        repeat (TMO - 1) @(negedge clk);
        checks++;
        if (bus.frame_active !== 1'b1 || bus.timeout_err !== 1'b0) begin
            failures++;
            $display("FAIL timeout_early got=%b/%b exp=1/0", bus.frame_active,
                     bus.timeout_err);
        end
        @(negedge clk);
        checks++;
        if (bus.timeout_err !== 1'b1 || bus.frame_active !== 1'b0 || bus.load_ready !== 1'b1) begin
            failures++;
            $display("FAIL timeout_abort got=%b/%b/%b exp=1/0/1", bus.timeout_err,
                     bus.frame_active, bus.load_ready);
        end
        d0 = LEN'($urandom);
        d1 = LEN'($urandom);
        run_edges(0, LEN-1, d0, d1, "timeout_next");
        @(negedge clk);
        checks++;
        if (bus.cap_valid !== 1'b1 || bus.cap_data !== {d1, d0}) begin
            failures++;
            $display("FAIL timeout_next_capture got=%b/%h exp=1/%h", bus.cap_valid,
                     bus.cap_data, {d1, d0});
        end
        bus.err_clear = 1'b1;
        @(negedge clk);
        bus.err_clear = 1'b0;
        checks++;
        if (bus.timeout_err !== 1'b0) begin
            failures++;
            $display("FAIL timeout_clear got=%b exp=0", bus.timeout_err);
        end
    endtask

    task automatic test_preload_collision();
        logic [LEN-1:0] d0, d1, p0, p1;
        d0 = LEN'($urandom);
        d1 = LEN'($urandom);
        p0 = LEN'($urandom);
        p1 = LEN'($urandom);
        @(negedge clk);
        checks++;
        if (bus.shift_out !== {m1[0], m0[0]}) begin
            failures++;
            $display("FAIL collide_shift_out got=%b exp=%b", bus.shift_out,
                     {m1[0], m0[0]});
        end
        bus.load_data  = {p1, p0};
        bus.load_valid = 1'b1;
        bus.shift_in   = {d1[0], d0[0]};
        bus.spi_clk    = 1'b1;
        m0 = {d0[0], m0[LEN-1:1]};
        m1 = {d1[0], m1[LEN-1:1]};
        #1;
        checks++;
        if (bus.load_ready !== 1'b0) begin
            failures++;
            $display("FAIL collide_ready_edge got=%b exp=0", bus.load_ready);
        end
        @(negedge clk);
        bus.spi_clk = 1'b0;
        run_edges(1, 7, d0, d1, "collide");
        checks++;
        if (bus.load_ready !== 1'b0) begin
            failures++;
            $display("FAIL collide_ready_mid got=%b exp=0", bus.load_ready);
        end
        run_edges(8, LEN-1, d0, d1, "collide");
        @(negedge clk);
        checks++;
        if (bus.cap_valid !== 1'b1 || bus.cap_data !== {d1, d0} || bus.load_ready !== 1'b1) begin
            failures++;
            $display("FAIL collide_capture got=%b/%h/%b exp=1/%h/1", bus.cap_valid,
                     bus.cap_data, bus.load_ready, {d1, d0});
        end
        @(negedge clk);
        bus.load_valid = 1'b0;
        m0 = p0;
        m1 = p1;
        run_edges(0, LEN-1, 16'h0, 16'h0, "collide_readback");
        @(negedge clk);
        checks++;
        if (bus.cap_data !== 32'h0) begin
            failures++;
            $display("FAIL collide_readback_capture got=%h exp=%h", bus.cap_data, 32'h0);
        end
    endtask

    task automatic test_reset_midframe();
        logic [LEN-1:0] d0, d1;
        d0 = LEN'($urandom) | 16'h0001;
        d1 = LEN'($urandom);
        run_edges(0, LEN-1, d0, d1, "rstmid_pre");
        @(negedge clk);
        d0 = LEN'($urandom);
        d1 = LEN'($urandom);
        run_edges(0, 6, d0, d1, "rstmid_part");
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.shift_out, bus.cap_valid, bus.overrun, bus.timeout_err,
             bus.frame_active} !== 6'b0) begin
            failures++;
            $display("FAIL rstmid_async got=%b exp=%b",
                     {bus.shift_out, bus.cap_valid, bus.overrun, bus.timeout_err,
                      bus.frame_active}, 6'b0);
        end
        checks++;
        if (bus.cap_data !== 32'h0) begin
            failures++;
            $display("FAIL rstmid_cap_data got=%h exp=%h", bus.cap_data, 32'h0);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        m0 = '0;
        m1 = '0;
        @(negedge clk);
        checks++;
        if (bus.load_ready !== 1'b1 || bus.frame_active !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_release got=%b/%b exp=1/0", bus.load_ready,
                     bus.frame_active);
        end
        d0 = LEN'($urandom);
        d1 = LEN'($urandom);
        run_edges(0, LEN-1, d0, d1, "rstmid_new");
        @(negedge clk);
        checks++;
        if (bus.cap_valid !== 1'b1 || bus.cap_data !== {d1, d0}) begin
            failures++;
            $display("FAIL rstmid_capture got=%b/%h exp=1/%h", bus.cap_valid,
                     bus.cap_data, {d1, d0});
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_basic();
        test_preload();
        test_random_frames();
        test_overrun();
        test_timeout();
        test_preload_collision();
        test_reset_midframe();
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
